// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode encodings and decode helpers shared by the shift register and its word counter
package shift_reg_pkg;
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_SET  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    function automatic logic is_count(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

    function automatic logic is_clear(input logic [2:0] m);
        return (m == MODE_LOAD) || (m == MODE_SET) || (m == MODE_CLR);
    endfunction
endpackage

// File: rtl/shift_word_cnt.sv
// shift_word_cnt: counts serial shifts and pulses o_word_vld for one cycle when a word completes
module shift_word_cnt #(
    parameter int WIDTH    = 8,
    parameter bit NEG_EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_shift,
    input  logic i_clr,
    output logic o_word_vld
);
    localparam int CW = $clog2(WIDTH);

    logic          w_clk;
    logic          w_last;
    logic [CW-1:0] r_cnt;
    logic          r_word_vld;

    assign w_clk      = clk ^ NEG_EDGE;
    assign w_last     = r_cnt == CW'(WIDTH - 1);
    assign o_word_vld = r_word_vld;

    // explicit wrap keeps non-power-of-two widths correct
    always_ff @(posedge w_clk or negedge rst)
        if (!rst) begin
            r_cnt      <= '0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= i_en & i_shift & w_last;
            if (i_en & i_clr)
                r_cnt <= '0;
            else if (i_en & i_shift)
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: shift/rotate/load register with selectable active clock edge and word-complete flag
module universal_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit NEG_EDGE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout_r,
    output logic             sout_l,
    output logic             word_vld
);
    logic             w_clk;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_q;

    assign w_clk  = clk ^ NEG_EDGE;
    assign q      = r_q;
    assign qb     = ~r_q;
    assign sout_r = r_q[0];
    assign sout_l = r_q[WIDTH-1];

    always_comb
        w_next = (mode == MODE_SHR)  ? {sin, r_q[WIDTH-1:1]} :
                 (mode == MODE_SHL)  ? {r_q[WIDTH-2:0], sin} :
                 (mode == MODE_ROR)  ? {r_q[0], r_q[WIDTH-1:1]} :
                 (mode == MODE_ROL)  ? {r_q[WIDTH-2:0], r_q[WIDTH-1]} :
                 (mode == MODE_LOAD) ? d :
                 (mode == MODE_SET)  ? '1 :
                 (mode == MODE_CLR)  ? '0 : r_q;

    always_ff @(posedge w_clk or negedge rst)
        if (!rst)
            r_q <= '0;
        else if (en)
            r_q <= w_next;

    shift_word_cnt #(.WIDTH(WIDTH), .NEG_EDGE(NEG_EDGE)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .i_shift    (is_count(mode)),
        .i_clr      (is_clear(mode)),
        .o_word_vld (word_vld)
    );
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed checks of a posedge and a negedge instance driven in lockstep
module tb_universal_shift_reg;
    import shift_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sin = 1'b0;
    logic [2:0] mode = MODE_HOLD;
    logic [7:0] d = 8'h00;
    logic [7:0] q_o[2];
    logic [7:0] qb_o[2];
    logic       sr_o[2];
    logic       sl_o[2];
    logic       vld_o[2];
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(8), .NEG_EDGE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .d(d),
        .q(q_o[0]), .qb(qb_o[0]), .sout_r(sr_o[0]), .sout_l(sl_o[0]), .word_vld(vld_o[0])
    );

    universal_shift_reg #(.WIDTH(8), .NEG_EDGE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .d(d),
        .q(q_o[1]), .qb(qb_o[1]), .sout_r(sr_o[1]), .sout_l(sl_o[1]), .word_vld(vld_o[1])
    );

    // one posedge and one negedge, so both instances see exactly one active edge
    task automatic cyc(input logic [2:0] m, input logic s, input logic e);
        mode = m;
        sin  = s;
        en   = e;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            if ({q_o[k], qb_o[k], sr_o[k], sl_o[k], vld_o[k]} !== {8'h00, 8'hFF, 3'b000}) begin
                $display("FAIL reset_state dut%0d got q=%h qb=%h sr=%b sl=%b vld=%b want q=00 qb=ff sr=0 sl=0 vld=0",
                         k, q_o[k], qb_o[k], sr_o[k], sl_o[k], vld_o[k]);
                n_fail++;
            end
            n_tests++;
        end
        d = 8'h5A;
        cyc(MODE_LOAD, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            if (q_o[k] !== 8'h00) begin
                $display("FAIL reset_ignores_inputs dut%0d got q=%h want 00", k, q_o[k]);
                n_fail++;
            end
            n_tests++;
        end
        rst = 1'b1;
    endtask

    task automatic test_modes;
        logic [2:0] mt[4] = '{MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL};
        logic       st[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] et[4] = '{8'hD2, 8'h4A, 8'hD2, 8'h4B};
        for (int i = 0; i < 4; i++) begin
            d = 8'hA5;
            cyc(MODE_LOAD, 1'b0, 1'b1);
            for (int k = 0; k < 2; k++) begin
                if ({q_o[k], qb_o[k], sr_o[k], sl_o[k]} !== {8'hA5, 8'h5A, 2'b11}) begin
                    $display("FAIL load_a5 dut%0d got q=%h qb=%h sr=%b sl=%b want q=a5 qb=5a sr=1 sl=1",
                             k, q_o[k], qb_o[k], sr_o[k], sl_o[k]);
                    n_fail++;
                end
                n_tests++;
            end
            cyc(mt[i], st[i], 1'b1);
            for (int k = 0; k < 2; k++) begin
                if (q_o[k] !== et[i]) begin
                    $display("FAIL mode%0d_from_a5 dut%0d got q=%h want %h", mt[i], k, q_o[k], et[i]);
                    n_fail++;
                end
                n_tests++;
            end
        end
        cyc(MODE_SET, 1'b0, 1'b1);
        cyc(MODE_HOLD, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            if ({q_o[k], sr_o[k], sl_o[k]} !== {8'hFF, 2'b11}) begin
                $display("FAIL set_hold dut%0d got q=%h sr=%b sl=%b want q=ff sr=1 sl=1", k, q_o[k], sr_o[k], sl_o[k]);
                n_fail++;
            end
            n_tests++;
        end
        cyc(MODE_CLR, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            if (q_o[k] !== 8'h00) begin
                $display("FAIL clr dut%0d got q=%h want 00", k, q_o[k]);
                n_fail++;
            end
            n_tests++;
        end
    endtask

    task automatic test_word;
        logic sv[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        cyc(MODE_CLR, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(MODE_SHR, sv[i], 1'b1);
            for (int k = 0; k < 2; k++) begin
                if (vld_o[k] !== (i == 7)) begin
                    $display("FAIL word_vld_shr edge%0d dut%0d got %b want %b", i + 1, k, vld_o[k], i == 7);
                    n_fail++;
                end
                n_tests++;
            end
        end
        cyc(MODE_HOLD, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            if ({q_o[k], vld_o[k]} !== {8'h4D, 1'b0}) begin
                $display("FAIL word_result dut%0d got q=%h vld=%b want q=4d vld=0", k, q_o[k], vld_o[k]);
                n_fail++;
            end
            n_tests++;
        end
    endtask

    task automatic test_load_clears;
        for (int i = 0; i < 5; i++)
            cyc(MODE_SHL, 1'b1, 1'b1);
        d = 8'h00;
        cyc(MODE_LOAD, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(MODE_SHL, 1'b1, 1'b1);
            for (int k = 0; k < 2; k++) begin
                if (vld_o[k] !== (i == 7)) begin
                    $display("FAIL load_clears_cnt edge%0d dut%0d got %b want %b", i + 1, k, vld_o[k], i == 7);
                    n_fail++;
                end
                n_tests++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (q_o[k] !== 8'hFF) begin
                $display("FAIL shl_fill dut%0d got q=%h want ff", k, q_o[k]);
                n_fail++;
            end
            n_tests++;
        end
    endtask

    task automatic test_enable;
        cyc(MODE_CLR, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc(MODE_SHR, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(MODE_SHR, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                if ({q_o[k], vld_o[k]} !== {8'hE0, 1'b0}) begin
                    $display("FAIL en_low_freeze dut%0d got q=%h vld=%b want q=e0 vld=0", k, q_o[k], vld_o[k]);
                    n_fail++;
                end
                n_tests++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            cyc(MODE_SHR, 1'b1, 1'b1);
            for (int k = 0; k < 2; k++) begin
                if (vld_o[k] !== (i == 4)) begin
                    $display("FAIL en_resume edge%0d dut%0d got %b want %b", i + 1, k, vld_o[k], i == 4);
                    n_fail++;
                end
                n_tests++;
            end
        end
    endtask

    task automatic test_mixed_back_to_back;
        logic [2:0] seq[11] = '{MODE_SHR, MODE_SHR, MODE_ROR, MODE_SHL, MODE_HOLD, MODE_SHR,
                                MODE_ROL, MODE_SHL, MODE_SHL, MODE_SHR, MODE_SHL};
        cyc(MODE_CLR, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            cyc(seq[i], 1'b1, 1'b1);
            for (int k = 0; k < 2; k++) begin
                if (vld_o[k] !== (i == 10)) begin
                    $display("FAIL mixed_dir step%0d dut%0d got %b want %b", i + 1, k, vld_o[k], i == 10);
                    n_fail++;
                end
                n_tests++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(MODE_SHR, 1'b0, 1'b1);
            for (int k = 0; k < 2; k++) begin
                if (vld_o[k] !== (i == 7)) begin
                    $display("FAIL back_to_back edge%0d dut%0d got %b want %b", i + 1, k, vld_o[k], i == 7);
                    n_fail++;
                end
                n_tests++;
            end
        end
    endtask

    task automatic test_async_reset;
        cyc(MODE_CLR, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            cyc(MODE_SHR, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            if (q_o[k] !== 8'hF0) begin
                $display("FAIL pre_reset_word dut%0d got q=%h want f0", k, q_o[k]);
                n_fail++;
            end
            n_tests++;
        end
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            if ({q_o[k], qb_o[k], sr_o[k], sl_o[k], vld_o[k]} !== {8'h00, 8'hFF, 3'b000}) begin
                $display("FAIL async_reset dut%0d got q=%h qb=%h sr=%b sl=%b vld=%b want q=00 qb=ff sr=0 sl=0 vld=0",
                         k, q_o[k], qb_o[k], sr_o[k], sl_o[k], vld_o[k]);
                n_fail++;
            end
            n_tests++;
        end
        cyc(MODE_SHR, 1'b1, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(MODE_SHR, 1'b1, 1'b1);
            for (int k = 0; k < 2; k++) begin
                if (vld_o[k] !== (i == 7)) begin
                    $display("FAIL post_reset_word edge%0d dut%0d got %b want %b", i + 1, k, vld_o[k], i == 7);
                    n_fail++;
                end
                n_tests++;
            end
        end
    endtask

    task automatic test_neg_edge;
        cyc(MODE_CLR, 1'b0, 1'b1);
        mode = MODE_SET;
        @(posedge clk);
        #1;
        if ({q_o[0], q_o[1]} !== {8'hFF, 8'h00}) begin
            $display("FAIL set_after_rise got pos=%h neg=%h want pos=ff neg=00", q_o[0], q_o[1]);
            n_fail++;
        end
        n_tests++;
        @(negedge clk);
        #1;
        if (q_o[1] !== 8'hFF) begin
            $display("FAIL set_after_fall got neg=%h want ff", q_o[1]);
            n_fail++;
        end
        n_tests++;
        mode = MODE_HOLD;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_word();
        test_load_clears();
        test_enable();
        test_mixed_back_to_back();
        test_async_reset();
        test_neg_edge();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
